mult_div_unit: RTL and testbench

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction, owns the HI/LO registers, and drives the BUSY signal that the hazard unit uses to stall mfhi/mflo/mthi/mtlo/mult/div in D. Results stay hidden until a fixed, instruction-dependent latency has elapsed.

---
 rtl/md_pkg.sv | 69 ++++++
 rtl/mult_div_unit.sv | 107 ++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings, defaults and arithmetic for the multiply/divide unit
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

    // Returns {HI, LO}. Signed divide works on magnitudes so that
    // -2^31 / -1 wraps to 0x80000000 with a zero remainder.
    function automatic logic [63:0] md_compute(input md_op_e op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        logic        a_neg;
        logic        b_neg;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] uq;
        logic [31:0] ur;
        logic [31:0] q;
        logic [31:0] r;
        if (op == MD_MULT || op == MD_MULTU) begin
            if (op == MD_MULT) begin
                wa = {{32{a[31]}}, a};
                wb = {{32{b[31]}}, b};
            end else begin
                wa = {32'd0, a};
                wb = {32'd0, b};
            end
            return wa * wb;
        end
        a_neg = (op == MD_DIV) && a[31];
        b_neg = (op == MD_DIV) && b[31];
        ua    = a_neg ? (32'd0 - a) : a;
        ub    = b_neg ? (32'd0 - b) : b;
        if (ub == 32'd0) begin
            ub = 32'd1;
        end
        uq = ua / ub;
        ur = ua % ub;
        q  = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        r  = a_neg ? (32'd0 - ur) : ur;
        return {r, q};
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit owning HI/LO with fixed-latency BUSY
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MD_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic          dz_q, dz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    md_op_e op;
    logic   start;
    logic   is_div;
    logic   commit;

    assign op     = md_op_e'(MD_op);
    assign start  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_RUN;
            end
        end else if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
        end
    end

    // Start term is combinational so a dependent instruction in D stalls in cycle 0.
    always_comb begin
        BUSY   = (state_q == ST_RUN) | start;
        commit = (state_q == ST_RUN) && (cnt_q == CW'(1));
    end

    always_comb begin
        cnt_d = cnt_q;
        res_d = res_q;
        dz_d  = dz_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                cnt_d = is_div ? DIV_CNT : MULT_CNT;
                res_d = md_compute(op, A, B);
                dz_d  = is_div && (B == 32'd0);
            end else if (op == MD_MTHI) begin
                hi_d = A;
            end else if (op == MD_MTLO) begin
                lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (commit && !dz_q) begin
                hi_d = res_q[63:32];
                lo_d = res_q[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            res_q <= '0;
            dz_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
            dz_q  <= dz_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against a longint reference model
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MD_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .MD_op (MD_op),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          vis;
        bit          set_hi;
        bit          set_lo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   run_end = -1;
    int   total   = 0;
    int   bad     = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, req);
        end
    endtask

    // Reference model: decides, for the cycle in which inputs are presented,
    // what becomes visible on HI/LO and when.
    task automatic model(input int c, input logic r, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t                 e;
        longint               sp;
        longint               sa;
        longint               sb;
        longint               sq;
        longint               sr;
        longint unsigned      up;
        longint unsigned      ua;
        longint unsigned      ub;
        e.vis = 0; e.set_hi = 0; e.set_lo = 0; e.hi = '0; e.lo = '0;
        if (r) begin
            while (exp_q.size() > 0 && exp_q[$].vis > c) void'(exp_q.pop_back());
            if (run_end > c) run_end = c;
            e.vis = c + 1; e.set_hi = 1; e.set_lo = 1;
            exp_q.push_back(e);
            return;
        end
        if (c <= run_end) return;
        case (op)
            3'd1, 3'd2: begin
                if (op == 3'd1) begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    up = longint'(sp);
                end else begin
                    ua = {32'd0, a};
                    ub = {32'd0, b};
                    up = ua * ub;
                end
                e.set_hi = 1; e.set_lo = 1;
                e.hi = up[63:32]; e.lo = up[31:0];
                run_end = c + MULT_N;
                e.vis = c + MULT_N + 1;
                exp_q.push_back(e);
            end
            3'd3, 3'd4: begin
                if (b != 32'd0) begin
                    if (op == 3'd3) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        sq = sa / sb;
                        sr = sa % sb;
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                        sq = sa / sb;
                        sr = sa % sb;
                    end
                    e.set_hi = 1; e.set_lo = 1;
                    e.hi = sr[31:0]; e.lo = sq[31:0];
                end
                run_end = c + DIV_N;
                e.vis = c + DIV_N + 1;
                exp_q.push_back(e);
            end
            3'd5: begin
                e.vis = c + 1; e.set_hi = 1; e.hi = a;
                exp_q.push_back(e);
            end
            3'd6: begin
                e.vis = c + 1; e.set_lo = 1; e.lo = a;
                exp_q.push_back(e);
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic r, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        reset = r; MD_op = op; A = a; B = b;
        model(cyc, r, op, a, b);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp[5];
        sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        logic        exp_busy;
        m_hi = '0;
        m_lo = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].vis <= cyc) begin
                e = exp_q.pop_front();
                if (e.set_hi) m_hi = e.hi;
                if (e.set_lo) m_lo = e.lo;
            end
            exp_busy = (cyc <= run_end) || (MD_op >= 3'd1 && MD_op <= 3'd4);
            chk("HI", HI, m_hi);
            chk("LO", LO, m_lo);
            chk("BUSY", {31'd0, BUSY}, {31'd0, exp_busy});
        end
    end

    initial begin : driver
        logic       r;
        logic [2:0] op;
        drive(1'b1, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 3'd0, 32'd0, 32'd0);
        mon_en = 1'b1;
        idle(1);

        drive(1'b0, 3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(MULT_N);
        drive(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd3);
        idle(MULT_N + 1);

        drive(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        drive(1'b0, 3'd4, 32'd7, 32'd2);
        idle(DIV_N + 1);

        drive(1'b0, 3'd5, 32'h11, 32'd0);
        drive(1'b0, 3'd6, 32'h22, 32'd0);
        drive(1'b0, 3'd3, 32'd9, 32'd0);
        idle(DIV_N);
        drive(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N + 1);

        drive(1'b0, 3'd1, 32'd1234, 32'hFFFF_0001);
        idle(1);
        drive(1'b0, 3'd6, 32'd5, 32'd0);
        idle(MULT_N - 2);
        drive(1'b0, 3'd6, 32'd5, 32'd0);
        idle(2);

        drive(1'b0, 3'd3, 32'd100, 32'd7);
        idle(2);
        drive(1'b1, 3'd0, 32'd0, 32'd0);
        drive(1'b0, 3'd1, 32'd6, 32'd7);
        idle(MULT_N + 1);

        drive(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000);
        idle(MULT_N - 1);
        drive(1'b0, 3'd4, 32'hFFFF_FFFF, 32'd10);
        idle(DIV_N + 1);

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            op = r ? 3'd0 : 3'($urandom_range(0, 7));
            drive(r, op, pick(), pick());
        end
        idle(DIV_N + 2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
